tinyalu_core: RTL and testbench

Responder end of the TinyALU command interface: the synthesizable ALU that the testbench BFM drives. The core accepts a command (A, B, op) qualified by `start`, executes add/and/xor in one cycle or an unsigned multiply through a 3-stage pipeline, returns `result` with a one-cycle `done` pulse, and then waits for `start` to be released before it accepts the next command. It is the DUT instantiated under the top-level testbench.

---
 rtl/tinyalu_core_if.sv | 15 +
 rtl/tinyalu_core.sv | 120 ++++++++++++
 tb/tb_tinyalu_core.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/tinyalu_core_if.sv
// Command/response bundle between the TinyALU requester (master) and the ALU core (slave).
interface tinyalu_core_if;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    // Handshake: the master holds start (with A/B/op) high until it samples done=1.
    // The slave pulses done for exactly one cycle and then waits for start=0 before
    // accepting again. result stays stable between completions.
    modport master (output A, B, op, start, input done, result);
    modport slave  (input A, B, op, start, output done, result);
endinterface

// File: rtl/tinyalu_core.sv
// TinyALU responder: add/and/xor in one cycle, unsigned 8x8 multiply through a
// 3-stage pipeline, one-cycle done pulse, then waits for start to drop.
module tinyalu_core (
    input  logic                  clk,
    input  logic                  reset_n,
    tinyalu_core_if.slave         bus,
    output logic [2:0]            dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_EXEC     = 3'd1,
        S_MUL1     = 3'd2,
        S_MUL2     = 3'd3,
        S_MUL3     = 3'd4,
        S_WAIT_LOW = 3'd5
    } state_e;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    state_e      state_q,  state_d;
    logic [7:0]  a_q,      a_d;
    logic [7:0]  b_q,      b_d;
    logic [2:0]  op_q,     op_d;
    logic [11:0] lo_q,     lo_d;
    logic [11:0] hi_q,     hi_d;
    logic [15:0] prod_q,   prod_d;
    logic [15:0] result_q, result_d;
    logic        done_q,   done_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        prod_d   = prod_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_ADD || bus.op == OP_AND || bus.op == OP_XOR) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        op_d    = bus.op;
                        state_d = S_EXEC;
                    end else if (bus.op == OP_MUL) begin
                        a_d     = bus.A;
                        b_d     = bus.B;
                        op_d    = bus.op;
                        state_d = S_MUL1;
                    end
                end
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD:  result_d = {7'b0, {1'b0, a_q} + {1'b0, b_q}};
                    OP_AND:  result_d = {8'h00, a_q & b_q};
                    default: result_d = {8'h00, a_q ^ b_q};
                endcase
                done_d  = 1'b1;
                state_d = S_WAIT_LOW;
            end
            // Product split into two 8x4 partial products, then summed and registered.
            S_MUL1: begin
                lo_d    = 12'(a_q) * 12'(b_q[3:0]);
                hi_d    = 12'(a_q) * 12'(b_q[7:4]);
                state_d = S_MUL2;
            end
            S_MUL2: begin
                prod_d  = 16'(lo_q) + (16'(hi_q) << 4);
                state_d = S_MUL3;
            end
            S_MUL3: begin
                result_d = prod_q;
                done_d   = 1'b1;
                state_d  = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (!bus.start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            prod_q   <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_tinyalu_core.sv
// Self-checking bench for tinyalu_core: expected results come from a small
// reference model pushed to exp_q at stimulus time and popped on done.
module tb_tinyalu_core;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] dbg_state;

    tinyalu_core_if bus ();

    tinyalu_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          passed = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_exp = 16'h0000;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd5;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [2:0] o);
        case (o)
            3'b001:  return 16'(a) + 16'(b);
            3'b010:  return {8'h00, a & b};
            3'b011:  return {8'h00, a ^ b};
            3'b100:  return 16'(a) * 16'(b);
            default: return 16'h0000;
        endcase
    endfunction

    // Called at posedge+1; drives the command so the next edge is t0. Returns the
    // done latency, the result seen with done, done one edge later, and the state then.
    task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                           output bit seen, output int lat, output logic [15:0] res,
                           output logic done_after, output logic [2:0] st_after);
        bus.A = a; bus.B = b; bus.op = o; bus.start = 1'b1;
        seen = 0; lat = 0; res = 'x;
        @(posedge clk);
        for (int i = 1; i <= 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                seen = 1; lat = i; res = bus.result;
            end
        end
        bus.start = 1'b0;
        @(posedge clk); #1;
        done_after = bus.done;
        st_after   = dbg_state;
    endtask

    task automatic test_reset();
        int cnt = 0;
        reset_n = 1'b0;
        bus.A = 8'h00; bus.B = 8'h00; bus.op = 3'b000; bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.done); else passed++;
        checks++; if (bus.result !== 16'h0000) $display("FAIL reset_result got=%h want=0000", bus.result); else passed++;
        checks++; if (dbg_state !== ST_IDLE) $display("FAIL reset_state got=%0d want=%0d", dbg_state, ST_IDLE); else passed++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) $display("FAIL idle_no_done got=%0d pulses want=0", cnt); else passed++;
    endtask

    task automatic test_logic_ops();
        logic [7:0]  a_t[3]  = '{8'hFF, 8'hF0, 8'hF0};
        logic [7:0]  b_t[3]  = '{8'hFF, 8'h3C, 8'h3C};
        logic [2:0]  o_t[3]  = '{3'b001, 3'b010, 3'b011};
        logic [15:0] lit[3]  = '{16'h01FE, 16'h0030, 16'h00CC};
        bit seen; int lat; logic [15:0] res, exp; logic dn; logic [2:0] st;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(model(a_t[i], b_t[i], o_t[i]));
            run_cmd(a_t[i], b_t[i], o_t[i], seen, lat, res, dn, st);
            exp = exp_q.pop_front();
            last_exp = exp;
            checks++; if (!seen || lat != 1) $display("FAIL op%0d_latency seen=%0d got=%0d want=1", o_t[i], seen, lat); else passed++;
            checks++; if (res !== exp || exp !== lit[i]) $display("FAIL op%0d_result got=%h want=%h", o_t[i], res, lit[i]); else passed++;
            checks++; if (dn !== 1'b0) $display("FAIL op%0d_done_width got=%b want=0", o_t[i], dn); else passed++;
        end
    endtask

    task automatic test_mul();
        bit seen; int lat; logic [15:0] res, exp; logic dn; logic [2:0] st;
        exp_q.push_back(model(8'hFF, 8'hFF, 3'b100));
        run_cmd(8'hFF, 8'hFF, 3'b100, seen, lat, res, dn, st);
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++; if (!seen || lat != 3) $display("FAIL mul_latency seen=%0d got=%0d want=3", seen, lat); else passed++;
        checks++; if (res !== 16'hFE01) $display("FAIL mul_result got=%h want=fe01", res); else passed++;
        checks++; if (dn !== 1'b0) $display("FAIL mul_done_width got=%b want=0", dn); else passed++;
    endtask

    task automatic test_operand_change_and_hold();
        bit seen = 0; int lat = 0; int cnt = 0; logic [15:0] res = 'x, exp;
        exp_q.push_back(model(8'h12, 8'h34, 3'b100));
        bus.A = 8'h12; bus.B = 8'h34; bus.op = 3'b100; bus.start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        bus.A = 8'h00; bus.B = 8'h00; bus.op = 3'b001;
        for (int i = 2; i <= 8 && !seen; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin seen = 1; lat = i; res = bus.result; end
        end
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++; if (!seen || lat != 3) $display("FAIL chg_latency seen=%0d got=%0d want=3", seen, lat); else passed++;
        checks++; if (res !== 16'h03A8) $display("FAIL chg_result got=%h want=03a8", res); else passed++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) $display("FAIL hold_second_done got=%0d want=0", cnt); else passed++;
        checks++; if (dbg_state !== ST_WAIT) $display("FAIL hold_state got=%0d want=%0d", dbg_state, ST_WAIT); else passed++;
        checks++; if (bus.result !== exp) $display("FAIL hold_result got=%h want=%h", bus.result, exp); else passed++;
        bus.start = 1'b0;
        @(posedge clk); #1;
        checks++; if (dbg_state !== ST_IDLE) $display("FAIL release_state got=%0d want=%0d", dbg_state, ST_IDLE); else passed++;
    endtask

    task automatic test_noop_illegal();
        logic [2:0] ops[2] = '{3'b000, 3'b110};
        for (int k = 0; k < 2; k++) begin
            int cnt = 0;
            bus.A = 8'h55; bus.B = 8'hAA; bus.op = ops[k]; bus.start = 1'b1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(posedge clk); #1;
                if (bus.done === 1'b1) cnt++;
            end
            checks++; if (cnt != 0) $display("FAIL op%0d_no_done got=%0d want=0", ops[k], cnt); else passed++;
            checks++; if (bus.result !== last_exp) $display("FAIL op%0d_result_kept got=%h want=%h", ops[k], bus.result, last_exp); else passed++;
            checks++; if (dbg_state !== ST_IDLE) $display("FAIL op%0d_state got=%0d want=%0d", ops[k], dbg_state, ST_IDLE); else passed++;
        end
    endtask

    task automatic test_reset_mid_mul();
        int cnt = 0;
        bit seen; int lat; logic [15:0] res, exp; logic dn; logic [2:0] st;
        bus.A = 8'h10; bus.B = 8'h10; bus.op = 3'b100; bus.start = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #2;
        checks++; if (bus.result !== 16'h0000) $display("FAIL abort_result got=%h want=0000", bus.result); else passed++;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) cnt++;
        end
        checks++; if (cnt != 0 || bus.done !== 1'b0) $display("FAIL abort_no_done got=%0d want=0", cnt); else passed++;
        checks++; if (dbg_state !== ST_IDLE) $display("FAIL abort_state got=%0d want=%0d", dbg_state, ST_IDLE); else passed++;
        reset_n = 1'b1;
        last_exp = 16'h0000;
        exp_q.push_back(model(8'h01, 8'h02, 3'b001));
        run_cmd(8'h01, 8'h02, 3'b001, seen, lat, res, dn, st);
        exp = exp_q.pop_front();
        last_exp = exp;
        checks++; if (!seen || lat != 1) $display("FAIL post_reset_latency seen=%0d got=%0d want=1", seen, lat); else passed++;
        checks++; if (res !== 16'h0003) $display("FAIL post_reset_result got=%h want=0003", res); else passed++;
    endtask

    task automatic test_back_to_back();
        bit seen; int lat; logic [15:0] res, exp; logic dn; logic [2:0] st;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] a = 8'($urandom_range(0, 255));
            logic [7:0] b = 8'($urandom_range(0, 255));
            logic [2:0] o = 3'($urandom_range(1, 4));
            int want_lat = (o == 3'b100) ? 3 : 1;
            exp_q.push_back(model(a, b, o));
            run_cmd(a, b, o, seen, lat, res, dn, st);
            exp = exp_q.pop_front();
            last_exp = exp;
            checks++; if (!seen || lat != want_lat) $display("FAIL b2b%0d_latency op=%0d got=%0d want=%0d", i, o, lat, want_lat); else passed++;
            checks++; if (res !== exp) $display("FAIL b2b%0d_result a=%h b=%h op=%0d got=%h want=%h", i, a, b, o, res, exp); else passed++;
            checks++; if (dn !== 1'b0 || st !== ST_IDLE) $display("FAIL b2b%0d_release done=%b state=%0d want 0/%0d", i, dn, st, ST_IDLE); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_logic_ops();
        test_mul();
        test_operand_change_and_hold();
        test_noop_illegal();
        test_reset_mid_mul();
        test_back_to_back();
        checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
